calendar_bcd_setter: RTL and testbench
======================================

Name: calendar_bcd_setter

Overview:
Holds a calendar date (year/month/day) that can be edited with push-button style step strobes.
It also advances autonomously by one day per day_tick.
It generalises the existing month/date/year setter with the following additions:
- full Gregorian leap rule (optional)
- increment and decrement
- tens-step
- day clamping on month/year change
- automatic day rollover
- parametrised year range and reset date
It sits between the keypad/debounce front end and the 7-segment scan driver, which consumes disp_bcd.

Parameters:
YEAR_MIN, 2000, lowest year; year wraps to this value
YEAR_MAX, 2299, highest year; year wraps from this value (YEAR_MIN <= YEAR_MAX <= 9999)
RESET_YEAR, 2000, year loaded at reset (binary)
RESET_MONTH, 1, month loaded at reset (1..12)
RESET_DAY, 1, day loaded at reset (must be valid for RESET_MONTH/RESET_YEAR)
GREGORIAN, 1, 1: leap = div4 and (not div100 or div400); 0: leap = div4 only

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
edit_en  in  1  1: edit mode, strobes act and day_tick is ignored
field_sel  in  2  0 day, 1 month, 2 year, 3 reserved (strobes ignored)
step_ten  in  1  1: step is 10, 0: step is 1 (month ignores this and always steps 1)
inc  in  1  single-cycle increment strobe
dec  in  1  single-cycle decrement strobe
day_tick  in  1  single-cycle advance-one-day strobe
show_year  in  1  selects the disp_bcd content
year_bcd  out  16  year, 4 BCD digits
mon_bcd  out  8  month, 2 BCD digits
day_bcd  out  8  day, 2 BCD digits
disp_bcd  out  16  show_year ? year_bcd : {mon_bcd, day_bcd}
leap  out  1  current year is leap
year_wrap  out  1  one-cycle pulse when day_tick rolls YEAR_MAX-12-31 to YEAR_MIN-01-01

Behaviour:
Clock, reset, latency:
- One clock: clk.
- Reset is synchronous, active-low, on rst_n. It has highest priority and takes effect on the next clk edge, even mid-edit.
- Reset values: date = RESET_YEAR/RESET_MONTH/RESET_DAY; all BCD outputs are the encoding of that date; disp_bcd = {mon_bcd, day_bcd} of the reset date; leap = leap(RESET_YEAR); year_wrap = 0.
- All outputs are registered. The state and outputs reflect a strobe on the clk edge after the strobe (1-cycle latency).
- disp_bcd follows show_year with 1-cycle latency.

Days in month (dim):
- 31 for months 1,3,5,7,8,10,12.
- 30 for months 4,6,9,11.
- 28 for month 2, or 29 if leap.

Priority each cycle:
- reset, then edit (edit_en=1), then day_tick (edit_en=0).
- inc=dec=1 in the same cycle: no change.
- field_sel=3: no change.

Day edit (step S = 1 or 10):
- inc: day = ((day-1+S) mod dim)+1.
- dec: day = ((day-1-S) mod dim)+1, using a non-negative modulo.
- Examples with dim=31: 31 inc 1 -> 1; 1 dec 1 -> 31; 25 inc 10 -> 4.

Month edit:
- inc: month 12 -> 1; dec: month 1 -> 12.
- After the change, day = min(day, dim(new month, year)).

Year edit (S = 1 or 10):
- Value wraps modulo the range: YEAR_MAX+1 -> YEAR_MIN, YEAR_MIN-1 -> YEAR_MAX.
- Tens step also wraps modulo (YEAR_MAX-YEAR_MIN+1).
- After the change, day is clamped as for a month edit (Feb 29 -> Feb 28 on a non-leap year).

day_tick:
- If day < dim: day+1.
- Else day = 1 and month+1.
- From month 12: month = 1 and year+1. If year was YEAR_MAX: year = YEAR_MIN and year_wrap pulses for exactly 1 cycle.

Invariants (checked by assertions):
- The date is always valid.
- Every BCD nibble is <= 9.
- year_wrap never asserts in edit mode.

Arithmetic:
- Internal state is binary: year 14b, month 4b, day 5b.
- BCD conversion is combinational ahead of the output registers. No division by non-constants: the year conversion uses a double-dabble or a digit-compare chain.

Decomposition:
- Shared package cal_pkg holds:
  - field_sel encodings (FLD_DAY, FLD_MONTH, FLD_YEAR)
  - a days_in_month(month, leap) function
  - an is_leap(year, gregorian) function
  - a bin2bcd4 function (14-bit to 4-digit BCD)
- One sub-module: cal_bin2bcd. It is a combinational 14-bit to 16-bit BCD converter, instanced for year, with a 7-bit variant for day and month.
- The rest is a single always block for state plus an output register stage.

Test Plan:
- Reset: hold rst_n=0 mid-edit with inc pulsing -> the cycle after, year_bcd=16'h2000, mon_bcd=8'h01, day_bcd=8'h01, disp_bcd=16'h0101, leap=1.
- Leap rollover with GREGORIAN=1:
  - 2000-02-28: day_tick x2 -> 02-29, then 03-01.
  - 2100-02-28: day_tick -> 2100-03-01; leap=0.
- Clamp: 2023-03-31, edit month dec -> 2023-02-28. Then year inc -> 2024-02-28. Set day inc -> 02-29. Then year inc -> 2025-02-28.
- Day wrap and tens step in month 4 (dim=30):
  - day 1 dec -> 30.
  - day 25 inc step_ten -> 05.
  - inc and dec together -> unchanged.
- Year boundary and wrap:
  - 2299-12-31, day_tick -> 2000-01-01 with year_wrap high for 1 cycle.
  - In edit, year 2000 dec step_ten -> 2290.
- Edit gating: edit_en=1 with day_tick pulses -> date unchanged. show_year toggle -> disp_bcd alternates 16'h2000 / 16'h0101 with 1-cycle latency.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared calendar definitions: field encodings, month lengths, leap rule and BCD conversion.
package cal_pkg;

  typedef enum logic [1:0] {
    FLD_DAY   = 2'd0,
    FLD_MONTH = 2'd1,
    FLD_YEAR  = 2'd2,
    FLD_RSVD  = 2'd3
  } field_e;

  function automatic logic is_leap(input logic [13:0] year, input logic gregorian);
    logic div4, div100, div400;
    div4   = (year[1:0] == 2'b00);
    div100 = ((year % 14'd100) == 14'd0);
    div400 = ((year % 14'd400) == 14'd0);
    return gregorian ? (div4 && (!div100 || div400)) : div4;
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return leap ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Shift-and-add-3 conversion; valid for inputs up to 9999.
  function automatic logic [15:0] bin2bcd4(input logic [13:0] bin);
    logic [29:0] sr;
    sr = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++)
        if (sr[14+4*d +: 4] > 4'd4) sr[14+4*d +: 4] = sr[14+4*d +: 4] + 4'd3;
      sr = sr << 1;
    end
    return sr[29:14];
  endfunction

endpackage

// File: rtl/cal_bin2bcd.sv
// Combinational binary to packed-BCD converter; BIN_W/BCD_W size it for year (14/16) or day/month (7/8).
module cal_bin2bcd #(
  parameter int BIN_W = 14,
  parameter int BCD_W = 16
) (
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd
);

  localparam int DIG = BCD_W / 4;

  logic [BIN_W+BCD_W-1:0] sr;

  always_comb begin
    sr = '0;
    sr[BIN_W-1:0] = bin;
    for (int i = 0; i < BIN_W; i++) begin
      for (int d = 0; d < DIG; d++)
        if (sr[BIN_W+4*d +: 4] > 4'd4) sr[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
      sr = sr << 1;
    end
  end

  assign bcd = sr[BIN_W +: BCD_W];

endmodule

// File: rtl/calendar_bcd_setter.sv
// Editable, self-advancing calendar date with registered BCD outputs for the display scanner.
module calendar_bcd_setter
  import cal_pkg::*;
#(
  parameter int YEAR_MIN    = 2000,
  parameter int YEAR_MAX    = 2299,
  parameter int RESET_YEAR  = 2000,
  parameter int RESET_MONTH = 1,
  parameter int RESET_DAY   = 1,
  parameter int GREGORIAN   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        edit_en,
  input  logic [1:0]  field_sel,
  input  logic        step_ten,
  input  logic        inc,
  input  logic        dec,
  input  logic        day_tick,
  input  logic        show_year,
  output logic [15:0] year_bcd,
  output logic [7:0]  mon_bcd,
  output logic [7:0]  day_bcd,
  output logic [15:0] disp_bcd,
  output logic        leap,
  output logic        year_wrap
);

  localparam int          RANGE     = YEAR_MAX - YEAR_MIN + 1;
  localparam logic        GREG      = (GREGORIAN != 0);
  localparam logic [13:0] YMIN      = 14'(YEAR_MIN);
  localparam logic [13:0] YMAX      = 14'(YEAR_MAX);
  localparam logic [13:0] RST_Y     = 14'(RESET_YEAR);
  localparam logic [15:0] RST_Y_BCD = bin2bcd4(RST_Y);
  localparam logic [15:0] RST_M_BCD = bin2bcd4(14'(RESET_MONTH));
  localparam logic [15:0] RST_D_BCD = bin2bcd4(14'(RESET_DAY));
  localparam logic        RST_LEAP  = is_leap(RST_Y, GREG);

  logic [13:0] year_p0, nxt_year;
  logic [3:0]  mon_p0, nxt_mon;
  logic [4:0]  day_p0, nxt_day;
  logic        nxt_wrap;
  logic [4:0]  dim_cur;
  logic [15:0] nxt_year_bcd;
  logic [7:0]  nxt_mon_bcd, nxt_day_bcd;

  always_comb begin
    int         step, yoff, ynew;
    logic [5:0] dsum;
    logic [4:0] dim_new;
    nxt_year = year_p0;
    nxt_mon  = mon_p0;
    nxt_day  = day_p0;
    nxt_wrap = 1'b0;
    dim_cur  = days_in_month(mon_p0, is_leap(year_p0, GREG));
    step     = step_ten ? 10 : 1;
    yoff     = int'(year_p0) - YEAR_MIN;
    ynew     = 0;
    dsum     = '0;
    dim_new  = '0;
    if (edit_en) begin
      if (inc ^ dec) begin
        case (field_e'(field_sel))
          FLD_DAY: begin
            // Offsetting by dim keeps the decrement path non-negative.
            if (inc) dsum = 6'(day_p0) - 6'd1 + 6'(step);
            else     dsum = 6'(day_p0) - 6'd1 + 6'(dim_cur) - 6'(step);
            if (dsum >= 6'(dim_cur)) dsum = dsum - 6'(dim_cur);
            nxt_day = 5'(dsum + 6'd1);
          end
          FLD_MONTH: begin
            if (inc) nxt_mon = (mon_p0 == 4'd12) ? 4'd1 : mon_p0 + 4'd1;
            else     nxt_mon = (mon_p0 == 4'd1) ? 4'd12 : mon_p0 - 4'd1;
          end
          FLD_YEAR: begin
            if (inc) ynew = (yoff + step) % RANGE;
            else     ynew = (yoff + RANGE - (step % RANGE)) % RANGE;
            nxt_year = 14'(YEAR_MIN + ynew);
          end
          default: ;
        endcase
        dim_new = days_in_month(nxt_mon, is_leap(nxt_year, GREG));
        if (nxt_day > dim_new) nxt_day = dim_new;
      end
    end else if (day_tick) begin
      if (day_p0 < dim_cur) begin
        nxt_day = day_p0 + 5'd1;
      end else begin
        nxt_day = 5'd1;
        if (mon_p0 == 4'd12) begin
          nxt_mon = 4'd1;
          if (year_p0 == YMAX) begin
            nxt_year = YMIN;
            nxt_wrap = 1'b1;
          end else begin
            nxt_year = year_p0 + 14'd1;
          end
        end else begin
          nxt_mon = mon_p0 + 4'd1;
        end
      end
    end
  end

  cal_bin2bcd #(.BIN_W(14), .BCD_W(16)) u_year_bcd (.bin(nxt_year),     .bcd(nxt_year_bcd));
  cal_bin2bcd #(.BIN_W(7),  .BCD_W(8))  u_mon_bcd  (.bin(7'(nxt_mon)), .bcd(nxt_mon_bcd));
  cal_bin2bcd #(.BIN_W(7),  .BCD_W(8))  u_day_bcd  (.bin(7'(nxt_day)), .bcd(nxt_day_bcd));

  // Stage p0 -> p1: binary date state and BCD output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      year_p0   <= RST_Y;
      mon_p0    <= 4'(RESET_MONTH);
      day_p0    <= 5'(RESET_DAY);
      year_bcd  <= RST_Y_BCD;
      mon_bcd   <= RST_M_BCD[7:0];
      day_bcd   <= RST_D_BCD[7:0];
      disp_bcd  <= {RST_M_BCD[7:0], RST_D_BCD[7:0]};
      leap      <= RST_LEAP;
      year_wrap <= 1'b0;
    end else begin
      year_p0   <= nxt_year;
      mon_p0    <= nxt_mon;
      day_p0    <= nxt_day;
      year_bcd  <= nxt_year_bcd;
      mon_bcd   <= nxt_mon_bcd;
      day_bcd   <= nxt_day_bcd;
      disp_bcd  <= show_year ? nxt_year_bcd : {nxt_mon_bcd, nxt_day_bcd};
      leap      <= is_leap(nxt_year, GREG);
      year_wrap <= nxt_wrap;
    end
  end

  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  a_date_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (mon_p0 >= 4'd1) && (mon_p0 <= 4'd12) && (day_p0 >= 5'd1) && (day_p0 <= dim_cur) &&
    (year_p0 >= YMIN) && (year_p0 <= YMAX));
  a_bcd_digits: assert property (@(posedge clk) disable iff (!rst_n)
    bcd_ok(year_bcd) && bcd_ok({mon_bcd, day_bcd}) && bcd_ok(disp_bcd));
  a_wrap_not_edit: assert property (@(posedge clk) disable iff (!rst_n)
    year_wrap |-> !$past(edit_en));

endmodule

// File: tb/tb_calendar_bcd_setter.sv
// Directed bench for calendar_bcd_setter: reset, leap rollover, clamping, wraps and edit gating.
module tb_calendar_bcd_setter;
  import cal_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, edit_en = 1'b0, step_ten = 1'b0;
  logic        inc = 1'b0, dec = 1'b0, day_tick = 1'b0, show_year = 1'b0;
  logic [1:0]  field_sel = 2'd0;
  logic [15:0] year_bcd, disp_bcd;
  logic [7:0]  mon_bcd, day_bcd;
  logic        leap, year_wrap;
  int          total = 0, bad = 0;

  calendar_bcd_setter dut (
    .clk(clk), .rst_n(rst_n), .edit_en(edit_en), .field_sel(field_sel), .step_ten(step_ten),
    .inc(inc), .dec(dec), .day_tick(day_tick), .show_year(show_year), .year_bcd(year_bcd),
    .mon_bcd(mon_bcd), .day_bcd(day_bcd), .disp_bcd(disp_bcd), .leap(leap), .year_wrap(year_wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; edit_en = 1'b0; inc = 1'b0; dec = 1'b0; day_tick = 1'b0; step_ten = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [1:0] f, input logic ten, input logic i, input logic d);
    edit_en = 1'b1; field_sel = f; step_ten = ten; inc = i; dec = d;
    cyc();
    inc = 1'b0; dec = 1'b0; step_ten = 1'b0;
  endtask

  task automatic tick();
    edit_en = 1'b0; day_tick = 1'b1;
    cyc();
    day_tick = 1'b0;
  endtask

  task automatic goto(input int y, input int m, input int d);
    do_reset();
    for (int k = 0; k < (y - 2000) / 10; k++) strobe(FLD_YEAR, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < (y - 2000) % 10; k++) strobe(FLD_YEAR, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < m - 1; k++)           strobe(FLD_MONTH, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < (d - 1) / 10; k++)    strobe(FLD_DAY, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < (d - 1) % 10; k++)    strobe(FLD_DAY, 1'b0, 1'b1, 1'b0);
    edit_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    edit_en = 1'b1; field_sel = FLD_YEAR; inc = 1'b1;
    cyc(); cyc();
    total++; if (year_bcd !== 16'h2002) begin bad++; $display("FAIL pre_reset_year got %h exp %h", year_bcd, 16'h2002); end
    rst_n = 1'b0;
    cyc();
    total++; if (year_bcd !== 16'h2000) begin bad++; $display("FAIL reset_year got %h exp %h", year_bcd, 16'h2000); end
    total++; if (mon_bcd !== 8'h01) begin bad++; $display("FAIL reset_mon got %h exp %h", mon_bcd, 8'h01); end
    total++; if (day_bcd !== 8'h01) begin bad++; $display("FAIL reset_day got %h exp %h", day_bcd, 8'h01); end
    total++; if (disp_bcd !== 16'h0101) begin bad++; $display("FAIL reset_disp got %h exp %h", disp_bcd, 16'h0101); end
    total++; if (leap !== 1'b1) begin bad++; $display("FAIL reset_leap got %b exp 1", leap); end
    total++; if (year_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b exp 0", year_wrap); end
    inc = 1'b0; edit_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_leap_rollover();
    goto(2000, 2, 28);
    total++; if (leap !== 1'b1) begin bad++; $display("FAIL leap_2000 got %b exp 1", leap); end
    tick();
    total++; if ({mon_bcd, day_bcd} !== 16'h0229) begin bad++; $display("FAIL tick_0229 got %h exp %h", {mon_bcd, day_bcd}, 16'h0229); end
    tick();
    total++; if ({mon_bcd, day_bcd} !== 16'h0301) begin bad++; $display("FAIL tick_0301 got %h exp %h", {mon_bcd, day_bcd}, 16'h0301); end
    goto(2100, 2, 28);
    tick();
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h21000301) begin bad++; $display("FAIL tick_2100 got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h21000301); end
    total++; if (leap !== 1'b0) begin bad++; $display("FAIL leap_2100 got %b exp 0", leap); end
  endtask

  task automatic test_clamp();
    goto(2023, 3, 31);
    strobe(FLD_MONTH, 1'b0, 1'b0, 1'b1);
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h20230228) begin bad++; $display("FAIL clamp_mon got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h20230228); end
    strobe(FLD_YEAR, 1'b0, 1'b1, 1'b0);
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h20240228) begin bad++; $display("FAIL year_2024 got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h20240228); end
    strobe(FLD_DAY, 1'b0, 1'b1, 1'b0);
    total++; if ({mon_bcd, day_bcd} !== 16'h0229) begin bad++; $display("FAIL day_0229 got %h exp %h", {mon_bcd, day_bcd}, 16'h0229); end
    strobe(FLD_YEAR, 1'b0, 1'b1, 1'b0);
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h20250228) begin bad++; $display("FAIL clamp_year got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h20250228); end
    total++; if (leap !== 1'b0) begin bad++; $display("FAIL leap_2025 got %b exp 0", leap); end
  endtask

  task automatic test_day_wrap();
    goto(2000, 4, 1);
    strobe(FLD_DAY, 1'b0, 1'b0, 1'b1);
    total++; if ({mon_bcd, day_bcd} !== 16'h0430) begin bad++; $display("FAIL day_dec_wrap got %h exp %h", {mon_bcd, day_bcd}, 16'h0430); end
    goto(2000, 4, 25);
    strobe(FLD_DAY, 1'b1, 1'b1, 1'b0);
    total++; if ({mon_bcd, day_bcd} !== 16'h0405) begin bad++; $display("FAIL day_ten_wrap got %h exp %h", {mon_bcd, day_bcd}, 16'h0405); end
    strobe(FLD_DAY, 1'b0, 1'b1, 1'b1);
    total++; if ({mon_bcd, day_bcd} !== 16'h0405) begin bad++; $display("FAIL inc_dec_both got %h exp %h", {mon_bcd, day_bcd}, 16'h0405); end
    strobe(2'd3, 1'b0, 1'b1, 1'b0);
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h20000405) begin bad++; $display("FAIL field_rsvd got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h20000405); end
  endtask

  task automatic test_year_wrap();
    goto(2299, 12, 31);
    tick();
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h20000101) begin bad++; $display("FAIL wrap_date got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h20000101); end
    total++; if (year_wrap !== 1'b1) begin bad++; $display("FAIL wrap_pulse got %b exp 1", year_wrap); end
    cyc();
    total++; if (year_wrap !== 1'b0) begin bad++; $display("FAIL wrap_single got %b exp 0", year_wrap); end
    strobe(FLD_YEAR, 1'b1, 1'b0, 1'b1);
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h22900101) begin bad++; $display("FAIL year_dec_ten got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h22900101); end
    strobe(FLD_YEAR, 1'b1, 1'b1, 1'b0);
    total++; if (year_bcd !== 16'h2000) begin bad++; $display("FAIL year_inc_ten got %h exp %h", year_bcd, 16'h2000); end
  endtask

  task automatic test_edit_gating();
    goto(2299, 12, 31);
    edit_en = 1'b1; field_sel = FLD_DAY; day_tick = 1'b1;
    cyc(); cyc(); cyc();
    total++; if ({year_bcd, mon_bcd, day_bcd} !== 32'h22991231) begin bad++; $display("FAIL gated_tick got %h exp %h", {year_bcd, mon_bcd, day_bcd}, 32'h22991231); end
    total++; if (year_wrap !== 1'b0) begin bad++; $display("FAIL gated_wrap got %b exp 0", year_wrap); end
    day_tick = 1'b0; edit_en = 1'b0;
    do_reset();
    show_year = 1'b1;
    #1;
    total++; if (disp_bcd !== 16'h0101) begin bad++; $display("FAIL disp_latency got %h exp %h", disp_bcd, 16'h0101); end
    cyc();
    total++; if (disp_bcd !== 16'h2000) begin bad++; $display("FAIL disp_year got %h exp %h", disp_bcd, 16'h2000); end
    show_year = 1'b0;
    #1;
    total++; if (disp_bcd !== 16'h2000) begin bad++; $display("FAIL disp_hold got %h exp %h", disp_bcd, 16'h2000); end
    cyc();
    total++; if (disp_bcd !== 16'h0101) begin bad++; $display("FAIL disp_date got %h exp %h", disp_bcd, 16'h0101); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_leap_rollover();
    test_clamp();
    test_day_wrap();
    test_year_wrap();
    test_edit_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
